pixel_arbiter: RTL and testbench
================================

# pixel_arbiter

Shares one `Counter` pixel-classification datapath between `N_SRC` independent pixel sources. The arbiter grants one source per image and holds that grant for exactly `IMG_SIZE` accepted pixels, so images are never interleaved. It then waits for the `Counter` result and reports it together with the source index. It sits between the source front-ends and the single `Counter` instance.

## Interface
Parameters:
- `N_SRC`, default 4: number of requesting sources; legal range 2..16.
- `IMG_SIZE`, default `MyDefine::IMG_SIZE`: pixels per image.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `src_valid`  in  `[N_SRC]`: per-source pixel valid.
- `src_ready`  out  `[N_SRC]`: per-source pixel ready.
- `src_data`  in  `[N_SRC][3][IMG_BIT]`: per-source RGB pixel.
- `src_tag`  in  `[N_SRC][TAG_BIT]`: per-source image tag.
- `pixel_valid`  out  1: to `Counter`.
- `pixel_ready`  in  1: from `Counter`.
- `pixel_data`  out  `[3][IMG_BIT]`: to `Counter`.
- `pixel_tag`  out  `TAG_BIT`: to `Counter`.
- `img_valid`  in  1: `Counter` result strobe.
- `res_valid`  out  1: one-cycle pulse, result available.
- `res_src`  out  `CL_N_SRC`: source index that owns the result.
- `busy`  out  1: high in every state except IDLE.

## Operation
FSM states: IDLE, GRANT, STREAM, WAIT_RES.
- **IDLE**: if any `src_valid` is high, select a winner, register it in `gnt`, and go to GRANT. If none is high, stay in IDLE.
- **Selection**: round-robin. The search starts at `ptr`, and the first index with `src_valid` high wins. On leaving STREAM, `ptr` becomes `gnt+1` modulo `N_SRC`.
- **GRANT**: lasts one cycle. Clears `beat_cnt` to 0, then goes to STREAM.
- **STREAM**: forwarding is combinational.
  - `pixel_valid = src_valid[gnt]`.
  - `pixel_data = src_data[gnt]`.
  - `pixel_tag = src_tag[gnt]`.
  - `src_ready[gnt] = pixel_ready`.
  - All other `src_ready` bits are 0.
- **Beat counting**: a beat is a cycle with `pixel_valid && pixel_ready`; each beat increments `beat_cnt`. The beat where `beat_cnt == IMG_SIZE-1` goes to WAIT_RES.
- **WAIT_RES**: all `src_ready` are 0 and `pixel_valid` is 0. When `img_valid` is seen:
  - `res_valid` is 1 for one cycle.
  - `res_src` is `gnt`.
  - The FSM goes to IDLE.
- **Widths**: `beat_cnt` is `$clog2(IMG_SIZE)` bits and never wraps. `ptr` and `gnt` are `CL_N_SRC` bits.
- **Stray result**: `img_valid` outside WAIT_RES is ignored. With `ARB_FIXED_PRIO_EN`, `stray_err` is also set (see Configuration).
- **Source deasserts mid-image**: the grant is held and the FSM stalls in STREAM. There is no timeout.
- **Requests during a grant**: other sources raising `src_valid` during STREAM or WAIT_RES see no effect until IDLE.
- **Reset, including mid-image**: the FSM goes to IDLE, `ptr`=0, `gnt`=0, `beat_cnt`=0. The partially sent image is abandoned; `Counter` is reset by the same `rst`.

## Timing
- Reset values:
  - `src_ready`=0, `pixel_valid`=0, `pixel_data`=0, `pixel_tag`=0.
  - `res_valid`=0, `res_src`=0, `busy`=0.
- Arbitration latency: `src_valid` high in IDLE at cycle t gives GRANT at t+1. The first pixel can be accepted at t+2.
- Throughput in STREAM: one pixel per cycle while both sides are ready.
- Result latency: `res_valid` is registered and appears the cycle after `img_valid` is sampled.
- Minimum per-image overhead: 1 IDLE cycle + 1 GRANT cycle + the `Counter` output cycle + 1 `res_valid` cycle.
- `res_valid` and a new arbitration never coincide; the FSM passes through IDLE.

## Configuration
- Macro: `ARB_FIXED_PRIO_EN`.
- **Defined**:
  - Selection is fixed priority: the lowest index with `src_valid` high wins, and `ptr` is unused.
  - Adds output `stray_err` (1 bit, reset 0). It is sticky high once `img_valid` arrives outside WAIT_RES, and only `rst` clears it.
- **Undefined**: round-robin selection as above; `stray_err` port is absent.

## Structure
- Additions to shared package `MyDefine`:
  - `N_SRC` and `CL_N_SRC = $clog2(N_SRC)`.
  - FSM enum `arb_state_t` {IDLE, GRANT, STREAM, WAIT_RES}.
  - Existing `IMG_BIT`, `TAG_BIT` and `IMG_SIZE` are reused from the package.
- Sub-module `rr_picker`: purely combinational, inputs `req[N_SRC]` and `ptr`, outputs `gnt_idx` and `any`. The fixed-priority variant is selected inside it under the macro.
- The FSM, counters and muxes are in `pixel_arbiter`.

## Test plan
- **Single source**: source 2 streams `IMG_SIZE` pixels, all red-dominant, tag 5. Required: `Counter` receives tag 5, and exactly one `res_valid` appears with `res_src`=2.
- **Round-robin fairness**: all 4 sources valid continuously. Required: grants go 0,1,2,3,0 across 5 images, and `res_src` follows that order.
- **Source gap**: source 1 drops `src_valid` for 3 cycles mid-image. Required: `beat_cnt` holds, no other source is granted, and the image completes with `res_src`=1.
- **Reset mid-stream**: assert `rst` after 10 beats. Required: the next cycle shows all outputs at reset values and `ptr`=0; a subsequent source 3 request is granted at t+1.
- **Back-pressure**: `pixel_ready` held 0 in STREAM. Required: `src_ready[gnt]`=0 and `beat_cnt` unchanged.
- **With `ARB_FIXED_PRIO_EN`**: sources 1 and 3 both valid. Required: source 1 wins every time. A stray `img_valid` in IDLE sets `stray_err`=1, which stays set until `rst`.

Source files
------------

// File: rtl/pixel_arbiter_pkg.sv
// Shared pixel-pipeline definitions (MyDefine): image geometry, tag width and
// the arbiter FSM encoding used by pixel_arbiter.
package MyDefine;
   localparam int IMG_BIT  = 8;
   localparam int TAG_BIT  = 4;
   localparam int IMG_SIZE = 16;
   localparam int N_SRC    = 4;
   localparam int CL_N_SRC = $clog2(N_SRC);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      STREAM,
      WAIT_RES
   } arb_state_t;
endpackage

// File: rtl/pixel_arbiter_rr_picker.sv
// Combinational winner selection for pixel_arbiter: round-robin from ptr, or
// lowest-index fixed priority when ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
   parameter int N_SRC = 4,
   parameter int CL_N  = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [CL_N-1:0]  ptr,
   output logic [CL_N-1:0]  gnt_idx,
   output logic             any
);

`ifdef ARB_FIXED_PRIO_EN
   logic ptr_unused;
   assign ptr_unused = ^ptr;

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      // Walk downwards so the lowest requesting index is the last one written.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_idx = CL_N'(i);
            any     = 1'b1;
         end
      end
   end
`else
   int idx;

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      // Largest offset first, so the requester closest to ptr wins.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (req[idx]) begin
            gnt_idx = CL_N'(idx);
            any     = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/pixel_arbiter.sv
// Grants one pixel source per image to the shared Counter datapath and reports
// the Counter result with the owning source. Option: ARB_FIXED_PRIO_EN.
module pixel_arbiter
   import MyDefine::arb_state_t, MyDefine::IDLE, MyDefine::GRANT,
          MyDefine::STREAM, MyDefine::WAIT_RES, MyDefine::IMG_BIT, MyDefine::TAG_BIT;
#(
   parameter  int N_SRC    = MyDefine::N_SRC,
   parameter  int IMG_SIZE = MyDefine::IMG_SIZE,
   localparam int CL_N     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_SRC-1:0]                    src_valid,
   output logic [N_SRC-1:0]                    src_ready,
   input  logic [N_SRC-1:0][2:0][IMG_BIT-1:0]  src_data,
   input  logic [N_SRC-1:0][TAG_BIT-1:0]       src_tag,
   output logic                                pixel_valid,
   input  logic                                pixel_ready,
   output logic [2:0][IMG_BIT-1:0]             pixel_data,
   output logic [TAG_BIT-1:0]                  pixel_tag,
   input  logic                                img_valid,
   output logic                                res_valid,
   output logic [CL_N-1:0]                     res_src,
`ifdef ARB_FIXED_PRIO_EN
   output logic                                stray_err,
`endif
   output logic                                busy
);

   localparam int               CNT_W     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IMG_SIZE - 1);
   localparam logic [CL_N-1:0]  LAST_SRC  = CL_N'(N_SRC - 1);

   arb_state_t       state_q, state_d;
   logic [CL_N-1:0]  gnt_q, gnt_d;
   logic [CL_N-1:0]  ptr_q, ptr_d;
   logic [CL_N-1:0]  res_src_q, res_src_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             res_valid_q, res_valid_d;
   logic [CL_N-1:0]  pick_idx;
   logic             pick_any;

   rr_picker #(
      .N_SRC (N_SRC),
      .CL_N  (CL_N)
   ) u_picker (
      .req     (src_valid),
      .ptr     (ptr_q),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      beat_cnt_d  = beat_cnt_q;
      res_src_d   = res_src_q;
      res_valid_d = 1'b0;
      src_ready   = '0;
      pixel_valid = 1'b0;
      pixel_data  = '0;
      pixel_tag   = '0;

      case (state_q)
         IDLE: begin
            // The res_valid cycle never starts a new arbitration.
            if (pick_any && !res_valid_q) begin
               gnt_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            beat_cnt_d = '0;
            state_d    = STREAM;
         end
         STREAM: begin
            pixel_valid      = src_valid[gnt_q];
            pixel_data       = src_data[gnt_q];
            pixel_tag        = src_tag[gnt_q];
            src_ready[gnt_q] = pixel_ready;
            if (src_valid[gnt_q] && pixel_ready) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = WAIT_RES;
                  ptr_d   = (gnt_q == LAST_SRC) ? '0 : gnt_q + 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         WAIT_RES: begin
            if (img_valid) begin
               res_valid_d = 1'b1;
               res_src_d   = gnt_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         ptr_q       <= '0;
         beat_cnt_q  <= '0;
         res_src_q   <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         res_src_q   <= res_src_d;
         res_valid_q <= res_valid_d;
      end
   end

`ifdef ARB_FIXED_PRIO_EN
   logic stray_err_q, stray_err_d;

   always_comb begin
      stray_err_d = stray_err_q | (img_valid && (state_q != WAIT_RES));
   end

   always_ff @(posedge clk) begin
      if (rst) stray_err_q <= 1'b0;
      else     stray_err_q <= stray_err_d;
   end

   assign stray_err = stray_err_q;
`endif

   assign res_valid = res_valid_q;
   assign res_src   = res_src_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_arbiter.sv
// Self-checking bench for pixel_arbiter: randomized sources and back-pressure
// against a per-image grant model. Build with or without ARB_FIXED_PRIO_EN.
module tb_pixel_arbiter;
   import MyDefine::*;

   localparam int NS  = 4;
   localparam int ISZ = IMG_SIZE;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [NS-1:0]                   src_valid, src_ready;
   logic [NS-1:0][2:0][IMG_BIT-1:0] src_data;
   logic [NS-1:0][TAG_BIT-1:0]      src_tag;
   logic                            pixel_valid, pixel_ready;
   logic [2:0][IMG_BIT-1:0]         pixel_data;
   logic [TAG_BIT-1:0]              pixel_tag;
   logic                            img_valid, res_valid, busy;
   logic [1:0]                      res_src;
`ifdef ARB_FIXED_PRIO_EN
   logic                            stray_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int ptr_m    = 0;   // model of the round-robin start point

   always #5 clk = ~clk;

   pixel_arbiter #(.N_SRC(NS), .IMG_SIZE(ISZ)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_data    (src_data),
      .src_tag     (src_tag),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .pixel_data  (pixel_data),
      .pixel_tag   (pixel_tag),
      .img_valid   (img_valid),
      .res_valid   (res_valid),
      .res_src     (res_src),
`ifdef ARB_FIXED_PRIO_EN
      .stray_err   (stray_err),
`endif
      .busy        (busy)
   );

   // Winner the arbiter should pick for a request mask.
   function automatic int model_pick(input logic [NS-1:0] mask);
      for (int off = 0; off < NS; off++) begin
`ifdef ARB_FIXED_PRIO_EN
         int idx = off;
`else
         int idx = (ptr_m + off) % NS;
`endif
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   // Random pixels on every source; the granted one is red-dominant with a fixed tag.
   task automatic drive_data(input int g, input logic [TAG_BIT-1:0] tag);
      for (int s = 0; s < NS; s++) begin
         for (int c = 0; c < 3; c++) src_data[s][c] = IMG_BIT'($urandom);
         src_tag[s] = TAG_BIT'($urandom);
      end
      src_data[g][0] = IMG_BIT'($urandom_range(128, 255));
      src_data[g][1] = IMG_BIT'($urandom_range(0, 127));
      src_data[g][2] = IMG_BIT'($urandom_range(0, 127));
      src_tag[g]     = tag;
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (src_ready !== '0 || pixel_valid !== 1'b0 || pixel_data !== '0 || pixel_tag !== '0 ||
          res_valid !== 1'b0 || res_src !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: rdy=%b pv=%b pd=%h pt=%h rv=%b rs=%0d busy=%b required all zero",
                  name, src_ready, pixel_valid, pixel_data, pixel_tag, res_valid, res_src, busy);
      end
`ifdef ARB_FIXED_PRIO_EN
      n_checks++;
      if (stray_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_stray: stray_err=%b required 0", name, stray_err);
      end
`endif
   endtask

   // One full image: IDLE -> GRANT -> STREAM -> WAIT_RES -> res_valid.
   // A nonzero abort_after asserts rst once that many beats have been accepted.
   task automatic do_image(input logic [NS-1:0] mask, input logic [TAG_BIT-1:0] tag,
                           input int gap_at, input int gap_len, input bit gap_is_src,
                           input bit rand_ready, input int abort_after);
      int            exp_src, beats, cyc, gap_left;
      logic          rdy;
      logic [NS-1:0] exp_ready;
      exp_src = model_pick(mask);

      @(negedge clk);
      src_valid = mask; pixel_ready = 1'b1; img_valid = 1'b0;
      drive_data(exp_src, tag);
      #1;
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || src_ready !== '0 || pixel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle: busy=%b rv=%b rdy=%b pv=%b required 0", busy, res_valid, src_ready, pixel_valid);
      end

      @(negedge clk); #1;
      n_checks++;
      if (busy !== 1'b1 || src_ready !== '0 || pixel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL grant: busy=%b rdy=%b pv=%b required busy=1 rest 0", busy, src_ready, pixel_valid);
      end

      beats = 0; cyc = 0; gap_left = gap_len;
      while (beats < ISZ && cyc < 300) begin
         @(negedge clk);
         cyc++;
         src_valid = mask;
         rdy = rand_ready ? 1'($urandom) : 1'b1;
         if (beats == gap_at && gap_left > 0) begin
            gap_left--;
            if (gap_is_src) src_valid[exp_src] = 1'b0;
            else            rdy = 1'b0;
         end
         pixel_ready = rdy;
         drive_data(exp_src, tag);
         #1;
         exp_ready = '0;
         exp_ready[exp_src] = rdy;
         n_checks++;
         if (pixel_valid !== src_valid[exp_src] || src_ready !== exp_ready || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_hs src%0d beat%0d: pv=%b rdy=%b busy=%b required pv=%b rdy=%b busy=1",
                     exp_src, beats, pixel_valid, src_ready, busy, src_valid[exp_src], exp_ready);
         end
         n_checks++;
         if (pixel_data !== src_data[exp_src] || pixel_tag !== tag) begin
            n_fail++;
            $display("FAIL stream_data src%0d: data=%h tag=%0d required data=%h tag=%0d",
                     exp_src, pixel_data, pixel_tag, src_data[exp_src], tag);
         end
         if (src_valid[exp_src] && rdy) beats++;
         if (abort_after > 0 && beats == abort_after) break;
      end
      if (cyc >= 300) begin
         n_fail++;
         $display("FAIL stream_timeout: %0d beats accepted, required %0d", beats, ISZ);
      end

      if (abort_after > 0) begin
         @(negedge clk);
         rst = 1'b1; src_valid = '0; pixel_ready = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         #1;
         check_reset_outputs("reset_mid_stream");
         ptr_m = 0;
         return;
      end

      ptr_m = (exp_src + 1) % NS;
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         src_valid = NS'($urandom); pixel_ready = 1'b1;
         #1;
         n_checks++;
         if (busy !== 1'b1 || pixel_valid !== 1'b0 || src_ready !== '0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_res: busy=%b pv=%b rdy=%b rv=%b required busy=1 rest 0",
                     busy, pixel_valid, src_ready, res_valid);
         end
      end
      @(negedge clk);
      img_valid = 1'b1;
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1 || src_ready !== '0) begin
         n_fail++;
         $display("FAIL img_cycle: rv=%b busy=%b rdy=%b required rv=0 busy=1 rdy=0", res_valid, busy, src_ready);
      end
      @(negedge clk);
      img_valid = 1'b0; src_valid = NS'($urandom) | NS'(1);
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_src !== 2'(exp_src) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL result: rv=%b res_src=%0d busy=%b required rv=1 res_src=%0d busy=0",
                  res_valid, res_src, busy, exp_src);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; src_valid = '0; pixel_ready = 1'b0; img_valid = 1'b0;
      src_data = '0; src_tag = '0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_source();
      do_image(4'b0100, 4'd5, -1, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 5; i++) do_image(4'b1111, TAG_BIT'(i), -1, 0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_source_gap();
      do_image(4'b1110, 4'd9, 6, 3, 1'b1, 1'b0, 0);
   endtask

   task automatic test_back_pressure();
      do_image(4'b0001, 4'd3, 4, 5, 1'b0, 1'b0, 0);
      do_image(4'b0101, 4'd7, 0, 3, 1'b0, 1'b1, 0);
   endtask

   task automatic test_stray();
      @(negedge clk);
      src_valid = '0; img_valid = 1'b1;
      @(negedge clk);
      img_valid = 1'b0;
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_ignored: rv=%b busy=%b required 0", res_valid, busy);
      end
`ifdef ARB_FIXED_PRIO_EN
      n_checks++;
      if (stray_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_set: stray_err=%b required 1", stray_err);
      end
`endif
   endtask

`ifdef ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      for (int i = 0; i < 3; i++) begin
         do_image(4'b1010, 4'd2, -1, 0, 1'b0, 1'b1, 0);
         n_checks++;
         if (stray_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_sticky: stray_err=%b required 1", stray_err);
         end
      end
   endtask
`endif

   task automatic test_reset_mid_stream();
      do_image(4'b0100, 4'd1, -1, 0, 1'b0, 1'b0, 0);
      do_image(4'b1000, 4'd4, -1, 0, 1'b0, 1'b0, 10);
      do_image(4'b1010, 4'd6, -1, 0, 1'b0, 1'b0, 0);
      do_image(4'b1000, 4'd8, -1, 0, 1'b0, 1'b1, 0);
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_source_gap();
      test_back_pressure();
      test_stray();
`ifdef ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
